vgachargen_map_sched: RTL and testbench
=======================================

// Module: vgachargen_map_sched
// PURPOSE
//  Sys-clock scheduler for the port-A (sys side) write/read ports of the ch_map and col_map BRAMs.
//  Shares one access slot per cycle between the host bus path and a built-in fill engine.
//  The fill engine clears or fills a screen region by writing {4{char}} / {4{colour}} words.
//  Sits between the APB slave decode and vgachargen; the factor-clock (VGA) side is untouched.
// PARAMETERS
//  FILL_BASE     0    first word address written by a fill (10-bit word addr, 4 chars/word)
//  FILL_WORDS    600  words per fill (80x30 chars / 4); FILL_BASE+FILL_WORDS <= 1024 (elab assert)
//  STARVE_LIMIT  4    consecutive host grants while fill pending before fill is forced one slot; >=1
// PORTS
//  clk_i            in   1   sys clock
//  arst_i           in   1   async reset, active-high
//  host_req_i       in   1   host access request, held until host_gnt_o
//  host_we_i        in   1   1=write, 0=read
//  host_sel_i       in   1   target: 0=ch_map, 1=col_map
//  host_addr_i      in   10  word address
//  host_wdata_i     in   32  write data
//  host_be_i        in   4   byte enables (write only)
//  host_gnt_o       out  1   access accepted this cycle (comb)
//  host_rvalid_o    out  1   read data valid (1 cycle after read grant)
//  host_rdata_o     out  32  read data
//  fill_start_i     in   1   start fill pulse
//  fill_abort_i     in   1   abort running fill
//  fill_ch_i        in   8   fill character code, sampled at start
//  fill_col_i       in   8   fill colour byte {fg,bg}, sampled at start
//  fill_busy_o      out  1   fill in progress
//  fill_done_o      out  1   1-cycle pulse after last fill write
//  ch_map_addr_o    out  10  to vgachargen ch_map_addr_i
//  ch_map_data_o    out  32  to vgachargen ch_map_data_i
//  ch_map_wen_o     out  4   to vgachargen ch_map_wen_i
//  ch_map_rdata_i   in   32  from vgachargen ch_map_data_o
//  col_map_addr_o   out  10  / col_map_data_o 32 / col_map_wen_o 4 / col_map_rdata_i 32: as ch_map
// BEHAVIOUR
//  Reset: FSM IDLE, all outputs 0, starve counter 0, fill_busy_o=0.
//  FSM: IDLE -(fill_start_i)-> FILL -(last word written)-> DONE -> IDLE (DONE lasts 1 cycle, fill_done_o=1).
//   FILL -(fill_abort_i)-> IDLE, no done pulse; words already written remain.
//   fill_start_i in FILL or DONE ignored. Start+abort same cycle in IDLE: start wins.
//  Arbitration per cycle: fill slot only in FILL. Host wins unless starve_cnt==STARVE_LIMIT.
//   starve_cnt: +1 on host grant while in FILL; cleared on fill grant or leaving FILL.
//  Fill grant: addr=FILL_BASE+cnt on both maps; ch data {4{ch}}, col data {4{col}}, both wen=4'hF.
//   cnt 10-bit, 0..FILL_WORDS-1; after grant at FILL_WORDS-1 go DONE; no wrap.
//  Host grant: host_gnt_o=host_req_i & ~fill_slot; drives only selected map's addr/data;
//   wen=host_be_i if write else 0; other map wen=0 (addr/data don't-care, held 0).
//  Host read: rvalid 1 cycle after grant; rdata muxed by registered sel from *_rdata_i (BRAM lat 1).
//   Fill write and host read never in same cycle; host read of an address mid-fill gets current contents.
//  Port outputs combinational from state/inputs; one access per cycle, never both requesters.
//  Reset mid-fill: immediate IDLE, wen 0, no done pulse.
// CONFIGURATION
//  VGACHARGEN_MAP_SCHED_IRQ_EN defined: extra ports irq_o (out 1) and irq_clr_i (in 1);
//   irq_o set on fill_done_o, held until irq_clr_i (clr wins on same cycle), reset 0.
//  Undefined: ports absent; fill_done_o is the only completion signal.
// STRUCTURE
//  vgachargen_pkg: MAP_ADDR_WIDTH=10, map_sched_state_t {IDLE,FILL,DONE}, map_sel_t {SEL_CH_MAP,SEL_COL_MAP}.
//  Sub-module vgachargen_fill_engine: FSM + word counter + sampled ch/col; exposes fill_req/fill_gnt.
//  Top holds arbiter, starve counter, read-valid/sel pipeline, optional irq flag.
// TESTING
//  Host write sel=0 addr=5 data=32'h41424344 be=4'hF, no fill -> gnt same cycle, ch_map_wen_o=4'hF, col wen 0.
//  Host read sel=1 addr=7 -> host_rvalid_o next cycle, host_rdata_o=col_map_rdata_i.
//  fill_start ch=8'h20 col=8'h0F, no host -> 600 writes addr 0..599 data 32'h20202020/32'h0F0F0F0F, done pulse.
//  Host req held high during fill -> pattern 4 host gnts, 1 fill gnt; fill completes in 3000 cycles.
//  fill_abort_i after 10 fill writes -> IDLE next cycle, fill_busy_o=0, no fill_done_o.
//  arst_i asserted mid-fill -> all wen 0 and busy 0 immediately; with IRQ_EN irq_o set after done, cleared by irq_clr_i.

Source files
------------

// File: rtl/vgachargen_pkg.sv
// Shared types and constants for the vgachargen sys-side map scheduler.
package vgachargen_pkg;

    localparam int MAP_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } map_sched_state_t;

    typedef enum logic {
        SEL_CH_MAP  = 1'b0,
        SEL_COL_MAP = 1'b1
    } map_sel_t;

endpackage

// File: rtl/vgachargen_fill_engine.sv
// Fill engine: walks FILL_WORDS consecutive map words from FILL_BASE and
// presents {4{ch}} / {4{col}} write words, advancing only when granted.
//
// state | meaning
// IDLE  | waiting for a start pulse
// FILL  | requesting a slot; one word written per grant
// DONE  | single cycle after the last word, raises done
module vgachargen_fill_engine
    import vgachargen_pkg::*;
#(
    parameter int FILL_BASE  = 0,
    parameter int FILL_WORDS = 600
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic                      start,
    input  logic                      abort,
    input  logic [7:0]                ch,
    input  logic [7:0]                col,
    input  logic                      gnt,
    output logic                      req,
    output logic [MAP_ADDR_WIDTH-1:0] addr,
    output logic [31:0]               ch_word,
    output logic [31:0]               col_word,
    output logic                      busy,
    output logic                      done
);

    localparam logic [MAP_ADDR_WIDTH-1:0] LAST_CNT = MAP_ADDR_WIDTH'(FILL_WORDS - 1);
    localparam logic [MAP_ADDR_WIDTH-1:0] BASE     = MAP_ADDR_WIDTH'(FILL_BASE);

    map_sched_state_t          state_q, state_d;
    logic [MAP_ADDR_WIDTH-1:0] cnt_q;
    logic [7:0]                ch_q, col_q;

    // Next-state: abort beats a pending last-word grant, start only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FILL;
            FILL: begin
                if (abort)                         state_d = IDLE;
                else if (gnt && cnt_q == LAST_CNT) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, word counter and fill bytes captured at start.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                cnt_q <= '0;
                ch_q  <= ch;
                col_q <= col;
            end else if (state_q == FILL && gnt && cnt_q != LAST_CNT) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign req      = (state_q == FILL);
    assign busy     = (state_q == FILL);
    assign done     = (state_q == DONE);
    assign addr     = BASE + cnt_q;
    assign ch_word  = {4{ch_q}};
    assign col_word = {4{col_q}};

endmodule

// File: rtl/vgachargen_map_sched.sv
// Sys-clock port-A scheduler for the ch_map / col_map BRAMs. One access per
// cycle, shared between the host bus path and the fill engine; the host wins
// unless the fill has been starved for STARVE_LIMIT consecutive host grants.
// Optional completion interrupt: define VGACHARGEN_MAP_SCHED_IRQ_EN.
module vgachargen_map_sched
    import vgachargen_pkg::*;
#(
    parameter int FILL_BASE    = 0,
    parameter int FILL_WORDS   = 600,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
`ifdef VGACHARGEN_MAP_SCHED_IRQ_EN
    output logic                      irq_o,
    input  logic                      irq_clr_i,
`endif
    input  logic                      host_req_i,
    input  logic                      host_we_i,
    input  logic                      host_sel_i,
    input  logic [MAP_ADDR_WIDTH-1:0] host_addr_i,
    input  logic [31:0]               host_wdata_i,
    input  logic [3:0]                host_be_i,
    output logic                      host_gnt_o,
    output logic                      host_rvalid_o,
    output logic [31:0]               host_rdata_o,
    input  logic                      fill_start_i,
    input  logic                      fill_abort_i,
    input  logic [7:0]                fill_ch_i,
    input  logic [7:0]                fill_col_i,
    output logic                      fill_busy_o,
    output logic                      fill_done_o,
    output logic [MAP_ADDR_WIDTH-1:0] ch_map_addr_o,
    output logic [31:0]               ch_map_data_o,
    output logic [3:0]                ch_map_wen_o,
    input  logic [31:0]               ch_map_rdata_i,
    output logic [MAP_ADDR_WIDTH-1:0] col_map_addr_o,
    output logic [31:0]               col_map_data_o,
    output logic [3:0]                col_map_wen_o,
    input  logic [31:0]               col_map_rdata_i
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    if (FILL_BASE + FILL_WORDS > (1 << MAP_ADDR_WIDTH) || FILL_WORDS < 1 || STARVE_LIMIT < 1)
    begin : g_bad_params
        $error("vgachargen_map_sched: fill region exceeds map or STARVE_LIMIT < 1");
    end

    logic                      fill_req, fill_slot, host_gnt, starve_hit;
    logic [MAP_ADDR_WIDTH-1:0] fill_addr;
    logic [31:0]               fill_ch_word, fill_col_word;
    logic [STARVE_W-1:0]       starve_cnt_q;
    logic                      rd_pend_q;
    map_sel_t                  host_sel, rd_sel_q;

    vgachargen_fill_engine #(
        .FILL_BASE  (FILL_BASE),
        .FILL_WORDS (FILL_WORDS)
    ) u_fill (
        .clk_i    (clk_i),
        .arst_i   (arst_i),
        .start    (fill_start_i),
        .abort    (fill_abort_i),
        .ch       (fill_ch_i),
        .col      (fill_col_i),
        .gnt      (fill_slot),
        .req      (fill_req),
        .addr     (fill_addr),
        .ch_word  (fill_ch_word),
        .col_word (fill_col_word),
        .busy     (fill_busy_o),
        .done     (fill_done_o)
    );

    assign host_sel   = map_sel_t'(host_sel_i);
    assign starve_hit = (starve_cnt_q == STARVE_W'(STARVE_LIMIT));
    assign fill_slot  = fill_req & (~host_req_i | starve_hit);
    assign host_gnt   = host_req_i & ~fill_slot;
    assign host_gnt_o = host_gnt;

    // Count host grants taken while the fill is waiting; reset once it gets a slot or stops.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i)                    starve_cnt_q <= '0;
        else if (!fill_req || fill_slot) starve_cnt_q <= '0;
        else if (host_gnt)             starve_cnt_q <= starve_cnt_q + 1'b1;
    end

    // Steer the single access slot onto the map ports; idle ports are held at zero.
    always_comb begin
        ch_map_addr_o  = '0;
        ch_map_data_o  = '0;
        ch_map_wen_o   = '0;
        col_map_addr_o = '0;
        col_map_data_o = '0;
        col_map_wen_o  = '0;
        if (fill_slot) begin
            ch_map_addr_o  = fill_addr;
            ch_map_data_o  = fill_ch_word;
            ch_map_wen_o   = 4'hF;
            col_map_addr_o = fill_addr;
            col_map_data_o = fill_col_word;
            col_map_wen_o  = 4'hF;
        end else if (host_gnt) begin
            if (host_sel == SEL_COL_MAP) begin
                col_map_addr_o = host_addr_i;
                col_map_data_o = host_wdata_i;
                col_map_wen_o  = host_we_i ? host_be_i : 4'h0;
            end else begin
                ch_map_addr_o  = host_addr_i;
                ch_map_data_o  = host_wdata_i;
                ch_map_wen_o   = host_we_i ? host_be_i : 4'h0;
            end
        end
    end

    // Track a granted read through the one-cycle BRAM latency, remembering which map it hit.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rd_pend_q <= 1'b0;
            rd_sel_q  <= SEL_CH_MAP;
        end else begin
            rd_pend_q <= host_gnt & ~host_we_i;
            rd_sel_q  <= host_sel;
        end
    end

    assign host_rvalid_o = rd_pend_q;
    assign host_rdata_o  = !rd_pend_q               ? 32'h0 :
                           (rd_sel_q == SEL_COL_MAP) ? col_map_rdata_i : ch_map_rdata_i;

`ifdef VGACHARGEN_MAP_SCHED_IRQ_EN
    // Sticky completion flag; a clear in the same cycle as done takes priority.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i)           irq_o <= 1'b0;
        else if (irq_clr_i)   irq_o <= 1'b0;
        else if (fill_done_o) irq_o <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_vgachargen_map_sched.sv
// Directed bench for vgachargen_map_sched: host write/read steering, full fill,
// fill under continuous host load, abort, start/abort collision, async reset.
module tb_vgachargen_map_sched;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic        host_req_i, host_we_i, host_sel_i;
    logic [9:0]  host_addr_i;
    logic [31:0] host_wdata_i;
    logic [3:0]  host_be_i;
    logic        host_gnt_o, host_rvalid_o;
    logic [31:0] host_rdata_o;
    logic        fill_start_i, fill_abort_i;
    logic [7:0]  fill_ch_i, fill_col_i;
    logic        fill_busy_o, fill_done_o;
    logic [9:0]  ch_map_addr_o, col_map_addr_o;
    logic [31:0] ch_map_data_o, col_map_data_o;
    logic [3:0]  ch_map_wen_o, col_map_wen_o;
    logic [31:0] ch_map_rdata_i, col_map_rdata_i;
`ifdef VGACHARGEN_MAP_SCHED_IRQ_EN
    logic        irq_o, irq_clr_i;
`endif

    int n_errors = 0;
    int n_checks = 0;

    vgachargen_map_sched dut (
        .clk_i           (clk_i),
        .arst_i          (arst_i),
`ifdef VGACHARGEN_MAP_SCHED_IRQ_EN
        .irq_o           (irq_o),
        .irq_clr_i       (irq_clr_i),
`endif
        .host_req_i      (host_req_i),
        .host_we_i       (host_we_i),
        .host_sel_i      (host_sel_i),
        .host_addr_i     (host_addr_i),
        .host_wdata_i    (host_wdata_i),
        .host_be_i       (host_be_i),
        .host_gnt_o      (host_gnt_o),
        .host_rvalid_o   (host_rvalid_o),
        .host_rdata_o    (host_rdata_o),
        .fill_start_i    (fill_start_i),
        .fill_abort_i    (fill_abort_i),
        .fill_ch_i       (fill_ch_i),
        .fill_col_i      (fill_col_i),
        .fill_busy_o     (fill_busy_o),
        .fill_done_o     (fill_done_o),
        .ch_map_addr_o   (ch_map_addr_o),
        .ch_map_data_o   (ch_map_data_o),
        .ch_map_wen_o    (ch_map_wen_o),
        .ch_map_rdata_i  (ch_map_rdata_i),
        .col_map_addr_o  (col_map_addr_o),
        .col_map_data_o  (col_map_data_o),
        .col_map_wen_o   (col_map_wen_o),
        .col_map_rdata_i (col_map_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int fill_n, host_n, both_n, done_k;
        bit done_seen;

        arst_i = 1'b1;
        host_req_i = 0; host_we_i = 0; host_sel_i = 0; host_addr_i = '0;
        host_wdata_i = '0; host_be_i = '0;
        fill_start_i = 0; fill_abort_i = 0; fill_ch_i = '0; fill_col_i = '0;
        ch_map_rdata_i = 32'h1111_1111; col_map_rdata_i = 32'hCAFE_BABE;
`ifdef VGACHARGEN_MAP_SCHED_IRQ_EN
        irq_clr_i = 0;
`endif
        #22;
        check("rst_ch_wen",  32'(ch_map_wen_o), 32'h0);
        check("rst_col_wen", 32'(col_map_wen_o), 32'h0);
        check("rst_busy",    32'(fill_busy_o), 32'h0);
        check("rst_done",    32'(fill_done_o), 32'h0);
        check("rst_rvalid",  32'(host_rvalid_o), 32'h0);
        check("rst_rdata",   host_rdata_o, 32'h0);
        arst_i = 1'b0;

        // host full write to ch_map
        next_cycle();
        host_req_i = 1; host_we_i = 1; host_sel_i = 0; host_addr_i = 10'd5;
        host_wdata_i = 32'h4142_4344; host_be_i = 4'hF;
        #1;
        check("wr_gnt",      32'(host_gnt_o), 32'h1);
        check("wr_ch_wen",   32'(ch_map_wen_o), 32'hF);
        check("wr_ch_addr",  32'(ch_map_addr_o), 32'd5);
        check("wr_ch_data",  ch_map_data_o, 32'h4142_4344);
        check("wr_col_wen",  32'(col_map_wen_o), 32'h0);

        // host partial write to col_map
        next_cycle();
        host_sel_i = 1; host_addr_i = 10'd9; host_wdata_i = 32'hDEAD_BEEF; host_be_i = 4'h3;
        #1;
        check("pw_col_wen",  32'(col_map_wen_o), 32'h3);
        check("pw_col_addr", 32'(col_map_addr_o), 32'd9);
        check("pw_col_data", col_map_data_o, 32'hDEAD_BEEF);
        check("pw_ch_wen",   32'(ch_map_wen_o), 32'h0);

        // host read of col_map
        next_cycle();
        host_we_i = 0; host_sel_i = 1; host_addr_i = 10'd7; host_be_i = 4'hF;
        #1;
        check("rd_gnt",      32'(host_gnt_o), 32'h1);
        check("rd_col_wen",  32'(col_map_wen_o), 32'h0);
        check("rd_col_addr", 32'(col_map_addr_o), 32'd7);
        check("rd_rvalid0",  32'(host_rvalid_o), 32'h0);
        next_cycle();
        host_req_i = 0;
        check("rd_rvalid1",  32'(host_rvalid_o), 32'h1);
        check("rd_rdata",    host_rdata_o, 32'hCAFE_BABE);
        next_cycle();
        check("rd_rvalid2",  32'(host_rvalid_o), 32'h0);

        // full fill with no host traffic; a stray start mid-fill is ignored
        fill_start_i = 1; fill_ch_i = 8'h20; fill_col_i = 8'h0F;
        next_cycle();
        fill_start_i = 0;
        check("fill_busy",   32'(fill_busy_o), 32'h1);
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin fill_start_i = 1; fill_ch_i = 8'h55; end
            if (i == 301) begin fill_start_i = 0; fill_ch_i = 8'h20; end
            #1;
            check($sformatf("fill_ch_addr[%0d]", i),  32'(ch_map_addr_o), 32'(i));
            check($sformatf("fill_col_addr[%0d]", i), 32'(col_map_addr_o), 32'(i));
            check($sformatf("fill_ch_data[%0d]", i),  ch_map_data_o, 32'h2020_2020);
            check($sformatf("fill_col_data[%0d]", i), col_map_data_o, 32'h0F0F_0F0F);
            check($sformatf("fill_wen[%0d]", i), 32'({ch_map_wen_o, col_map_wen_o}), 32'hFF);
            check($sformatf("fill_nodone[%0d]", i), 32'(fill_done_o), 32'h0);
            next_cycle();
        end
        check("fill_done",     32'(fill_done_o), 32'h1);
        check("fill_done_wen", 32'(ch_map_wen_o), 32'h0);
        next_cycle();
        check("fill_done_end", 32'(fill_done_o), 32'h0);
        check("fill_idle_wen", 32'(col_map_wen_o), 32'h0);
`ifdef VGACHARGEN_MAP_SCHED_IRQ_EN
        check("irq_set", 32'(irq_o), 32'h1);
        irq_clr_i = 1;
        next_cycle();
        irq_clr_i = 0;
        check("irq_clr", 32'(irq_o), 32'h0);
`endif

        // fill with host read held high: 4 host grants then 1 fill grant
        host_req_i = 1; host_we_i = 0; host_sel_i = 0; host_addr_i = 10'd3;
        fill_start_i = 1; fill_ch_i = 8'hAA; fill_col_i = 8'h55;
        next_cycle();
        fill_start_i = 0;
        fill_n = 0; host_n = 0; both_n = 0; done_k = -1; done_seen = 0;
        for (int k = 0; k < 4000; k++) begin
            #1;
            if (fill_done_o) begin
                done_seen = 1;
                done_k = k;
                break;
            end
            if (ch_map_wen_o == 4'hF) fill_n++;
            if (host_gnt_o) host_n++;
            if (host_gnt_o && ch_map_wen_o != 4'h0) both_n++;
            if (k < 10)
                check($sformatf("starve_pat[%0d]", k), 32'(host_gnt_o), (k % 5 == 4) ? 32'h0 : 32'h1);
            if (k == 4) begin
                check("starve_first_addr", 32'(ch_map_addr_o), 32'd0);
                check("starve_first_data", col_map_data_o, 32'h5555_5555);
            end
            next_cycle();
        end
        check("starve_done_seen", 32'(done_seen), 32'h1);
        check("starve_cycles",    32'(done_k), 32'd3000);
        check("starve_fill_n",    32'(fill_n), 32'd600);
        check("starve_host_n",    32'(host_n), 32'd2400);
        check("starve_both_n",    32'(both_n), 32'd0);
        host_req_i = 0;
        next_cycle();

        // abort after 10 fill writes
        fill_start_i = 1; fill_ch_i = 8'h41; fill_col_i = 8'h07;
        next_cycle();
        fill_start_i = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("abort_addr[%0d]", i), 32'(ch_map_addr_o), 32'(i));
            next_cycle();
        end
        fill_abort_i = 1;
        next_cycle();
        fill_abort_i = 0;
        check("abort_busy", 32'(fill_busy_o), 32'h0);
        check("abort_wen",  32'({ch_map_wen_o, col_map_wen_o}), 32'h0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort_nodone[%0d]", i), 32'(fill_done_o), 32'h0);
            next_cycle();
        end

        // start and abort together in IDLE: start wins; then async reset mid-fill
        fill_start_i = 1; fill_abort_i = 1;
        next_cycle();
        fill_start_i = 0; fill_abort_i = 0;
        check("sa_busy",  32'(fill_busy_o), 32'h1);
        check("sa_wen",   32'(ch_map_wen_o), 32'hF);
        next_cycle();
        next_cycle();
        #2;
        arst_i = 1;
        #1;
        check("arst_ch_wen",  32'(ch_map_wen_o), 32'h0);
        check("arst_col_wen", 32'(col_map_wen_o), 32'h0);
        check("arst_busy",    32'(fill_busy_o), 32'h0);
        check("arst_done",    32'(fill_done_o), 32'h0);
        #10;
        arst_i = 0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check($sformatf("post_arst_busy[%0d]", i), 32'(fill_busy_o), 32'h0);
            check($sformatf("post_arst_done[%0d]", i), 32'(fill_done_o), 32'h0);
            check($sformatf("post_arst_wen[%0d]", i),  32'(ch_map_wen_o), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
